// File: rtl/debug_display_scanner_pkg.sv
// Shared constants for the debug display scanner:
// page encoding and the active-low hex glyph table.
package debug_disp_pkg;

  localparam logic [2:0] PAGE_PC_WB = 3'd0;
  localparam logic [2:0] PAGE_HI    = 3'd1;
  localparam logic [2:0] PAGE_LO    = 3'd2;
  localparam logic [2:0] PAGE_V0    = 3'd3;
  localparam logic [2:0] PAGE_V1    = 3'd4;
  localparam int         NUM_PAGES  = 5;

  // {g,f,e,d,c,b,a}, active-low; entry 15 first
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [2:0] next_page(
    input logic [2:0] p
  );
    if (p == 3'(NUM_PAGES - 1))
      return PAGE_PC_WB;
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/debug_display_scanner_seg7.sv
// Nibble to active-low seven-segment glyph.
// Pure table lookup, no state.
module hex_to_seg7
  import debug_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH[nibble];

endmodule

// File: rtl/debug_display_scanner.sv
// Eight-digit multiplexed hex display of pipeline debug
// registers, with a debounced page button and freeze.
module debug_display_scanner
  import debug_disp_pkg::*;
#(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Debug_Program_Counter,
  input  logic [31:0] Debug_Write_Register,
  input  logic [31:0] Debug_HI,
  input  logic [31:0] Debug_LO,
  input  logic [31:0] Debug_V0,
  input  logic [31:0] Debug_V1,
  input  logic        page_btn,
  input  logic        freeze,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic [2:0]  page
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic          wrap;
  logic [31:0]   snap;
  logic [31:0]   snap_nxt;
  logic [31:0]   page_word;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          sync0;
  logic          sync1;
  logic          deb;
  logic [CW-1:0] dcnt;
  logic          inc;
  logic          unused_hi;

  assign unused_hi = ^{Debug_Program_Counter[31:16],
                       Debug_Write_Register[31:16]};

  always_comb begin
    tick      = (presc == PW'(REFRESH_DIV - 1));
    idx_nxt   = idx + 3'd1;
    wrap      = tick && (idx == 3'd7);
    page_word = {Debug_Program_Counter[15:0],
                 Debug_Write_Register[15:0]};
    unique case (1'b1)
      page == PAGE_HI: page_word = Debug_HI;
      page == PAGE_LO: page_word = Debug_LO;
      page == PAGE_V0: page_word = Debug_V0;
      page == PAGE_V1: page_word = Debug_V1;
      default: ;
    endcase
    snap_nxt = (wrap && !freeze) ? page_word : snap;
    // glyph is fetched for the digit about to be lit
    nib = 4'(snap_nxt >> {idx_nxt, 2'b00});
  end

  hex_to_seg7 u_seg (
    .nibble (nib),
    .seg    (glyph)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      presc  <= '0;
      idx    <= '0;
      snap   <= '0;
      out7   <= 7'h7F;
      en_out <= 8'hFF;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      snap  <= snap_nxt;
      if (tick) begin
        idx    <= idx_nxt;
        out7   <= glyph;
        en_out <= ~(8'd1 << idx_nxt);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      deb   <= 1'b0;
      dcnt  <= '0;
      inc   <= 1'b0;
      page  <= PAGE_PC_WB;
    end else begin
      sync0 <= page_btn;
      sync1 <= sync0;
      inc   <= 1'b0;
      if (sync1 != deb) begin
        if (dcnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb  <= sync1;
          dcnt <= '0;
          inc  <= sync1;
        end else begin
          dcnt <= dcnt + CW'(1);
        end
      end else begin
        dcnt <= '0;
      end
      // same-edge reload in the scan block still sees the old page
      if (inc)
        page <= next_page(page);
    end
  end

endmodule

// File: tb/tb_debug_display_scanner.sv
// Self-checking bench for debug_display_scanner using a
// cycle-count display model and randomized page traffic.
module tb_debug_display_scanner;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] wr = '0;
  logic [31:0] hi = '0;
  logic [31:0] lo = '0;
  logic [31:0] v0 = '0;
  logic [31:0] v1 = '0;
  logic        btn = 1'b0;
  logic        frz = 1'b0;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic [2:0]  page;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  debug_display_scanner #(
    .REFRESH_DIV     (DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .Clk                   (clk),
    .Reset                 (reset_n),
    .Debug_Program_Counter (pc),
    .Debug_Write_Register  (wr),
    .Debug_HI              (hi),
    .Debug_LO              (lo),
    .Debug_V0              (v0),
    .Debug_V1              (v1),
    .page_btn              (btn),
    .freeze                (frz),
    .out7                  (out7),
    .en_out                (en_out),
    .page                  (page)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [31:0] page_val(input int p);
    case (p)
      1: return hi;
      2: return lo;
      3: return v0;
      4: return v1;
      default: return {pc[15:0], wr[15:0]};
    endcase
  endfunction

  function automatic logic [7:0] en_of(input int d);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << d);
  endfunction

  task automatic do_reset;
    reset_n = 1'b0;
    btn = 1'b0;
    frz = 1'b0;
    step(2);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(2);
    tests++;
    if (en_out !== 8'hFF) begin
      fails++;
      $display("FAIL rst_en: got %h want ff", en_out);
    end
    tests++;
    if (out7 !== 7'h7F) begin
      fails++;
      $display("FAIL rst_seg: got %h want 7f", out7);
    end
    tests++;
    if (page !== 3'd0) begin
      fails++;
      $display("FAIL rst_page: got %0d want 0", page);
    end
    reset_n = 1'b1;
    cyc = 0;
    step(3);
    tests++;
    if (en_out !== 8'hFF) begin
      fails++;
      $display("FAIL pre_tick_en: got %h want ff", en_out);
    end
    step(1);
    tests++;
    if (en_out !== en_of(1) || out7 !== glyph(4'h0)) begin
      fails++;
      $display("FAIL first_tick: got en %h seg %b want en %h seg %b",
               en_out, out7, en_of(1), glyph(4'h0));
    end
  endtask

  task automatic test_page0;
    pc = 32'h0000_1234;
    wr = 32'h0000_ABCD;
    do_reset();
    step(32);
    tests++;
    if (en_out !== 8'hFE || out7 !== 7'b0100001) begin
      fails++;
      $display("FAIL page0_d0: got en %h seg %b want fe 0100001",
               en_out, out7);
    end
    step(28);
    tests++;
    if (en_out !== 8'h7F || out7 !== 7'b1111001) begin
      fails++;
      $display("FAIL page0_d7: got en %h seg %b want 7f 1111001",
               en_out, out7);
    end
  endtask

  task automatic test_hi_page;
    step(4);
    hi = 32'h89AB_CDEF;
    btn = 1'b1;
    step(6);
    tests++;
    if (page !== 3'd1) begin
      fails++;
      $display("FAIL hi_page: got %0d want 1", page);
    end
    btn = 1'b0;
    step(96 - cyc);
    tests++;
    if (en_out !== 8'hFE || out7 !== 7'b0001110) begin
      fails++;
      $display("FAIL hi_d0: got en %h seg %b want fe 0001110",
               en_out, out7);
    end
    step(28);
    tests++;
    if (en_out !== 8'h7F || out7 !== 7'b0000000) begin
      fails++;
      $display("FAIL hi_d7: got en %h seg %b want 7f 0000000",
               en_out, out7);
    end
  endtask

  task automatic test_glitch;
    pc = 32'h0000_1234;
    wr = 32'h0000_ABCD;
    do_reset();
    step(32);
    repeat (3) begin
      btn = 1'b1;
      step(2);
      btn = 1'b0;
      step(2);
    end
    step(8);
    tests++;
    if (page !== 3'd0) begin
      fails++;
      $display("FAIL glitch_page: got %0d want 0", page);
    end
    step(64 - cyc);
    tests++;
    if (page !== 3'd0 || out7 !== 7'b0100001) begin
      fails++;
      $display("FAIL glitch_snap: got page %0d seg %b want 0 0100001",
               page, out7);
    end
  endtask

  task automatic test_freeze;
    v0 = 32'h1;
    do_reset();
    repeat (3) begin
      btn = 1'b1;
      step(8);
      btn = 1'b0;
      step(8);
    end
    tests++;
    if (page !== 3'd3) begin
      fails++;
      $display("FAIL frz_page: got %0d want 3", page);
    end
    step(64 - cyc);
    tests++;
    if (en_out !== 8'hFE || out7 !== 7'b1111001) begin
      fails++;
      $display("FAIL frz_pre: got en %h seg %b want fe 1111001",
               en_out, out7);
    end
    frz = 1'b1;
    v0 = 32'h2;
    for (int f = 0; f < 3; f++) begin
      step(32);
      tests++;
      if (out7 !== 7'b1111001) begin
        fails++;
        $display("FAIL frz_hold%0d: got %b want 1111001", f, out7);
      end
    end
    frz = 1'b0;
    step(32);
    tests++;
    if (en_out !== 8'hFE || out7 !== 7'b0100100) begin
      fails++;
      $display("FAIL frz_release: got en %h seg %b want fe 0100100",
               en_out, out7);
    end
  endtask

  task automatic test_back_to_back;
    int starts [5] = '{0, 16, 32, 58, 80};
    int pages  [5] = '{1, 2, 3, 4, 0};
    pc = 32'h0000_0000;
    wr = 32'h0000_000A;
    hi = 32'h1;
    lo = 32'h2;
    v0 = 32'h3;
    v1 = 32'h4;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      btn = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (c >= starts[k] && c < starts[k] + 8)
          btn = 1'b1;
        if (c == starts[k] + 6) begin
          tests++;
          if (page !== 3'(pages[k])) begin
            fails++;
            $display("FAIL seq_page%0d: got %0d want %0d",
                     k, page, pages[k]);
          end
        end
      end
      if (c == 64) begin
        tests++;
        if (en_out !== 8'hFE || out7 !== glyph(v0[3:0])) begin
          fails++;
          $display("FAIL coincide: got en %h seg %b want fe %b",
                   en_out, out7, glyph(v0[3:0]));
        end
      end
      if (c == 96) begin
        tests++;
        if (out7 !== glyph(wr[3:0])) begin
          fails++;
          $display("FAIL wrap_to_0: got %b want %b",
                   out7, glyph(wr[3:0]));
        end
      end
      step(1);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    repeat (3) begin
      btn = 1'b1;
      step(8);
      btn = 1'b0;
      step(8);
    end
    step(116 - cyc);
    tests++;
    if (en_out !== en_of(5) || page !== 3'd3) begin
      fails++;
      $display("FAIL mid_pre: got en %h page %0d want %h 3",
               en_out, page, en_of(5));
    end
    btn = 1'b1;
    step(2);
    reset_n = 1'b0;
    btn = 1'b0;
    step(1);
    tests++;
    if (en_out !== 8'hFF || out7 !== 7'h7F || page !== 3'd0) begin
      fails++;
      $display("FAIL mid_rst: got en %h seg %h page %0d want ff 7f 0",
               en_out, out7, page);
    end
    reset_n = 1'b1;
    cyc = 0;
    step(3);
    tests++;
    if (en_out !== 8'hFF) begin
      fails++;
      $display("FAIL mid_blank: got %h want ff", en_out);
    end
    step(1);
    tests++;
    if (en_out !== en_of(1)) begin
      fails++;
      $display("FAIL mid_first: got %h want %h", en_out, en_of(1));
    end
    step(10);
    tests++;
    if (page !== 3'd0) begin
      fails++;
      $display("FAIL mid_residual: got %0d want 0", page);
    end
  endtask

  task automatic test_random;
    int mpage;
    int ps;
    logic [31:0] exp_snap;
    mpage = 0;
    pc = $urandom;
    wr = $urandom;
    hi = $urandom;
    lo = $urandom;
    v0 = $urandom;
    v1 = $urandom;
    do_reset();
    step(28);
    exp_snap = page_val(0);
    step(4);
    for (int f = 0; f < 8; f++) begin
      ps = ($urandom_range(0, 1) == 0) ? 8 : $urandom_range(0, 3);
      for (int d = 0; d < 8; d++) begin
        tests++;
        if (en_out !== en_of(d) ||
            out7 !== glyph(exp_snap[4*d +: 4])) begin
          fails++;
          $display("FAIL rnd_f%0d_d%0d: got en %h seg %b want %h %b",
                   f, d, en_out, out7, en_of(d),
                   glyph(exp_snap[4*d +: 4]));
        end
        if (d == ps) begin
          btn = 1'b1;
          mpage = (mpage + 1) % 5;
        end
        if (d == ps + 2)
          btn = 1'b0;
        if (d == 5) begin
          tests++;
          if (page !== 3'(mpage)) begin
            fails++;
            $display("FAIL rnd_page_f%0d: got %0d want %0d",
                     f, page, mpage);
          end
          pc = $urandom;
          wr = $urandom;
          hi = $urandom;
          lo = $urandom;
          v0 = $urandom;
          v1 = $urandom;
          frz = ($urandom_range(0, 3) == 0);
        end
        if (d == 7 && !frz)
          exp_snap = page_val(mpage);
        step(4);
      end
    end
    frz = 1'b0;
  endtask

  initial begin
    test_reset();
    test_page0();
    test_hi_page();
    test_glitch();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_display_scanner.md
DEBUG_DISPLAY_SCANNER -- requirements
Module: debug_display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, Clk cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-level cycles before the page button is accepted (minimum 1).
REQ-003 SHALL have port Clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-low reset (0 = reset, sampled on Clk rising edge).
REQ-005 SHALL have port Debug_Program_Counter  input  32  PC of the pipeline under observation.
REQ-006 SHALL have port Debug_Write_Register  input  32  write-back data of the pipeline.
REQ-007 SHALL have ports Debug_HI, Debug_LO, Debug_V0, Debug_V1  input  32 each  HI/LO and $v0/$v1 contents.
REQ-008 SHALL have port page_btn  input  1  asynchronous raw push-button; advances the page.
REQ-009 SHALL have port freeze  input  1  when 1, holds the displayed snapshot.
REQ-010 SHALL have port out7  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port en_out  output  8  digit anodes, active-low; bit 0 = rightmost digit.
REQ-012 SHALL have port page  output  3  currently selected page.

Function
REQ-013 Page map SHALL be: 0 = {PC[15:0], WriteReg[15:0]}; 1 = HI; 2 = LO; 3 = V0; 4 = V1. Page 4 advances to 0.
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap. tick SHALL be asserted on the cycle count = REFRESH_DIV-1.
REQ-015 On tick, digit index SHALL advance 0->7 and wrap 7->0.
REQ-016 Digit i SHALL display snapshot nibble [4i+3:4i] as a hex glyph 0-F.
REQ-017 out7 and en_out SHALL be registered and SHALL reflect the new digit index 1 cycle after tick. Exactly one en_out bit SHALL be low outside reset.
REQ-018 The 32-bit snapshot SHALL be reloaded from the selected page on the tick that wraps the index 7->0, unless freeze = 1. No tearing within a frame.
REQ-019 page_btn SHALL pass through a 2-flop synchronizer.
REQ-020 The debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the old level SHALL clear the counter.
REQ-021 A debounced 0->1 edge SHALL increment page modulo 5 on the following cycle. Button release SHALL have no effect.
REQ-022 A page change SHALL take effect on the display at the next snapshot reload.
REQ-023 Simultaneous page increment and snapshot reload: the reload SHALL use the old page.
REQ-024 freeze SHALL NOT stop scanning, debouncing or page changes.

Reset
REQ-025 While Reset = 0 at a clock edge, the following SHALL hold: prescaler = 0, digit index = 0, page = 0, snapshot = 0, debounce state = 0, synchronizer = 0, en_out = 8'hFF, out7 = 7'h7F.
REQ-026 After Reset returns to 1, the first tick SHALL occur REFRESH_DIV cycles later and SHALL light digit 1. Digit 0 SHALL be lit with snapshot 0 after the next wrap.
REQ-027 Reset mid-frame or mid-debounce SHALL abandon all progress with no residual page advance.

Structure
REQ-028 The package debug_disp_pkg SHALL hold the page encoding constants (PAGE_PC_WB..PAGE_V1, NUM_PAGES = 5) and the 16-entry active-low glyph table.
REQ-029 Combinational nibble-to-glyph decoding SHALL be a sub-module hex_to_seg7 (4 in, 7 out). Prescaler, scan, debounce and page logic SHALL be inline.

Verification (bench: REFRESH_DIV = 4, DEBOUNCE_CYCLES = 3)
REQ-030 Reset, PC = 0x00001234, WriteReg = 0x0000ABCD, after one full frame: digit 0 SHALL show out7 = 7'b0100001 ("d") with en_out = 8'hFE, and digit 7 SHALL show out7 = 7'b1111001 ("1") with en_out = 8'h7F.
REQ-031 With HI = 0x89ABCDEF, page_btn held high 6 cycles: page SHALL = 1 within 6 cycles; after the next wrap, digit 0 SHALL show "F" (7'b0001110) and digit 7 SHALL show "8" (7'b0000000).
REQ-032 With page_btn pulses of 2 cycles separated by 2-cycle lows: page SHALL remain 0 and the snapshot SHALL be unchanged.
REQ-033 With freeze = 1, V0 changing 0x1 -> 0x2 on page 3 across 3 frames: digit 0 SHALL stay "1" (7'b1111001). After freeze = 0, it SHALL show "2" (7'b0100100) after the next wrap.
REQ-034 Five accepted presses from page 0 SHALL produce the page sequence 1, 2, 3, 4, 0. A press coinciding with a wrap tick SHALL load the old page's value.
REQ-035 Reset asserted 1 cycle while the digit index = 5 and page = 3: next cycle SHALL show en_out = 8'hFF, out7 = 7'h7F, page = 0, and the first subsequent lit digit SHALL be 1.
